// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_decoder
//  Purpose  : PS/2 set-2 receiver. Decodes make/break codes (including the
//             E0 and F0 prefixes) into 3-bit key events and queues them in a
//             first-word-fall-through FIFO.
//  Config   : PS2_PARITY_CHECK_EN enables odd-parity checking of each byte.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] key_code,
    output logic       key_release,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [5:0] key_held,
    output logic       overflow,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW:0]   DEPTH     = (PW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input synchroniser and stability filter; index 0 = clock, 1 = data
    // ------------------------------------------------------------------
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_filt;
    logic [FW-1:0] r_fcnt [2];
    logic          r_clk_prev;
    logic          w_strobe;
    logic          w_dat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_filt     <= 2'b11;
            r_clk_prev <= 1'b1;
            for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
        end else begin
            r_sync1    <= {ps2_data, ps2_clk};
            r_sync2    <= r_sync1;
            r_clk_prev <= r_filt[0];
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FILT_LAST) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_strobe = r_clk_prev & ~r_filt[0];
    assign w_dat    = r_filt[1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t        r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          r_byte_done;
    logic [7:0]    r_byte;
    logic          r_frame_err;
    logic          w_timeout;
    logic          w_par_odd;
    logic          w_parity_ok;

    assign w_par_odd = ^{r_shift, r_parity};
`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = w_par_odd;
`else
    // Parity is still captured so the frame format is unchanged; it just never rejects.
    assign w_parity_ok = w_par_odd | 1'b1;
`endif

    assign w_timeout = (r_state != S_IDLE) && !w_strobe && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_done <= 1'b0;
            r_byte      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_strobe || r_state == S_IDLE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_LAST) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_timeout) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
            end else if (w_strobe) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_dat) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift  <= {w_dat, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_parity <= w_dat;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (w_dat && w_parity_ok) begin
                            r_byte_done <= 1'b1;
                            r_byte      <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte decode, prefix flags and held-key tracking
    // ------------------------------------------------------------------
    logic       r_ext;
    logic       r_brk;
    logic [5:0] r_held;
    logic       w_mapped;
    logic [2:0] w_code;
    logic       w_emit;

    always_comb begin
        w_mapped = 1'b1;
        w_code   = 3'd0;
        if (r_ext) begin
            case (r_byte)
                8'h75:   w_code = 3'd0;
                8'h72:   w_code = 3'd1;
                8'h6B:   w_code = 3'd2;
                8'h74:   w_code = 3'd3;
                8'h5A:   w_code = 3'd4;
                default: w_mapped = 1'b0;
            endcase
        end else begin
            case (r_byte)
                8'h1D:   w_code = 3'd0;
                8'h1B:   w_code = 3'd1;
                8'h1C:   w_code = 3'd2;
                8'h23:   w_code = 3'd3;
                8'h29:   w_code = 3'd4;
                8'h5A:   w_code = 3'd4;
                8'h76:   w_code = 3'd5;
                default: w_mapped = 1'b0;
            endcase
        end
    end

    // Typematic repeats (make of a held key) and stray breaks are swallowed.
    assign w_emit = r_byte_done && w_mapped && (r_brk ? r_held[w_code] : !r_held[w_code]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_held <= '0;
        end else if (w_timeout) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_done) begin
            if (r_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (w_emit) r_held[w_code] <= !r_brk;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_full = (r_count == DEPTH);
    assign w_pop  = key_valid && key_ready;
    assign w_push = w_emit && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_overflow <= w_emit && w_full && !w_pop;
            if (w_push) begin
                r_mem[r_wr] <= {r_brk, w_code};
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign key_code    = r_mem[r_rd][2:0];
    assign key_release = r_mem[r_rd][3];
    assign key_valid   = (r_count != '0);
    assign key_held    = r_held;
    assign overflow    = r_overflow;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Purpose  : Directed, table-driven self-checking bench for ps2_key_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] key_code;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;
    logic [5:0] key_held;
    logic       overflow;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_key_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_code    (key_code),
        .key_release (key_release),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int err_pulses  = 0;
    int ovf_pulses  = 0;

    always @(negedge clk) begin
        if (frame_err) err_pulses++;
        if (overflow)  ovf_pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] b;
        logic       ev;
        logic [2:0] code;
        logic       rel;
        logic [5:0] held;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] b, input logic ev, input logic [2:0] code,
                       input logic rel, input logic [5:0] held);
        vec_t v;
        v.b = b; v.ev = ev; v.code = code; v.rel = rel; v.held = held;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sends the first nbits bits of an 11-bit frame, then leaves the bus idle.
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int e0;
        int o0;
        reset     = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        key_ready = 1'b0;
        do_reset();

        check("reset key_valid",   key_valid,   0);
        check("reset key_code",    key_code,    0);
        check("reset key_release", key_release, 0);
        check("reset key_held",    key_held,    0);
        check("reset overflow",    overflow,    0);
        check("reset frame_err",   frame_err,   0);

        add(8'h1D, 1, 0, 0, 6'b000001);
        add(8'hF0, 0, 0, 0, 6'b000001);
        add(8'h1D, 1, 0, 1, 6'b000000);
        add(8'hE0, 0, 0, 0, 6'b000000);
        add(8'h75, 1, 0, 0, 6'b000001);
        add(8'hE0, 0, 0, 0, 6'b000001);
        add(8'hF0, 0, 0, 0, 6'b000001);
        add(8'h75, 1, 0, 1, 6'b000000);
        add(8'h1C, 1, 2, 0, 6'b000100);
        add(8'h1C, 0, 0, 0, 6'b000100);
        add(8'h1C, 0, 0, 0, 6'b000100);
        add(8'hF0, 0, 0, 0, 6'b000100);
        add(8'h1C, 1, 2, 1, 6'b000000);
        add(8'hF0, 0, 0, 0, 6'b000000);
        add(8'h1B, 0, 0, 0, 6'b000000);
        add(8'h1B, 1, 1, 0, 6'b000010);
        add(8'hE0, 0, 0, 0, 6'b000010);
        add(8'h72, 0, 0, 0, 6'b000010);
        add(8'hF0, 0, 0, 0, 6'b000010);
        add(8'h72, 0, 0, 0, 6'b000010);
        add(8'hF0, 0, 0, 0, 6'b000010);
        add(8'h1B, 1, 1, 1, 6'b000000);
        add(8'hAA, 0, 0, 0, 6'b000000);
        add(8'hE0, 0, 0, 0, 6'b000000);
        add(8'hAA, 0, 0, 0, 6'b000000);
        add(8'h75, 0, 0, 0, 6'b000000);
        add(8'h5A, 1, 4, 0, 6'b010000);
        add(8'hE0, 0, 0, 0, 6'b010000);
        add(8'hF0, 0, 0, 0, 6'b010000);
        add(8'h5A, 1, 4, 1, 6'b000000);
        add(8'h76, 1, 5, 0, 6'b100000);
        add(8'hF0, 0, 0, 0, 6'b100000);
        add(8'h76, 1, 5, 1, 6'b000000);
        add(8'h23, 1, 3, 0, 6'b001000);
        add(8'hE0, 0, 0, 0, 6'b001000);
        add(8'h74, 0, 0, 0, 6'b001000);
        add(8'hF0, 0, 0, 0, 6'b001000);
        add(8'h23, 1, 3, 1, 6'b000000);
        add(8'hE0, 0, 0, 0, 6'b000000);
        add(8'h6B, 1, 2, 0, 6'b000100);
        add(8'hE0, 0, 0, 0, 6'b000100);
        add(8'hF0, 0, 0, 0, 6'b000100);
        add(8'h6B, 1, 2, 1, 6'b000000);

        for (int i = 0; i < tbl.size(); i++) begin
            send_frame(tbl[i].b, 1'b0, 1'b1, 11);
            check($sformatf("v%0d byte %h valid", i, tbl[i].b), key_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                check($sformatf("v%0d code", i), key_code, tbl[i].code);
                check($sformatf("v%0d release", i), key_release, tbl[i].rel);
                repeat (3) @(negedge clk);
                check($sformatf("v%0d head stable", i), {key_valid, key_release, key_code},
                      {1'b1, tbl[i].rel, tbl[i].code});
                pop_one();
                check($sformatf("v%0d valid after pop", i), key_valid, 0);
            end
            check($sformatf("v%0d key_held", i), key_held, tbl[i].held);
        end

        // FIFO fill and overflow with the consumer stalled
        do_reset();
        o0 = ovf_pulses;
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        send_frame(8'h1B, 1'b0, 1'b1, 11);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        send_frame(8'h23, 1'b0, 1'b1, 11);
        check("fifo no overflow at 4", ovf_pulses - o0, 0);
        send_frame(8'h29, 1'b0, 1'b1, 11);
        check("fifo overflow pulse cycles", ovf_pulses - o0, 1);
        check("fifo key_held", key_held, 6'b011111);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fifo pop %0d valid", k), key_valid, 1);
            check($sformatf("fifo pop %0d code", k), key_code, k);
            check($sformatf("fifo pop %0d release", k), key_release, 0);
            pop_one();
        end
        check("fifo empty after pops", key_valid, 0);

        // Reset in the middle of a prefix drops the extended flag
        do_reset();
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        do_reset();
        send_frame(8'h75, 1'b0, 1'b1, 11);
        check("reset clears ext valid", key_valid, 0);

        // Bad stop bit
        e0 = err_pulses;
        send_frame(8'h1D, 1'b0, 1'b0, 11);
        check("bad stop frame_err", err_pulses - e0, 1);
        check("bad stop no event", key_valid, 0);
        check("bad stop key_held", key_held, 0);

        // Partial frame then timeout
        e0 = err_pulses;
        send_frame(8'h1D, 1'b0, 1'b1, 3);
        repeat (20100) @(posedge clk);
        @(negedge clk);
        check("timeout frame_err", err_pulses - e0, 1);
        check("timeout no event", key_valid, 0);

        e0 = err_pulses;
        send_frame(8'h76, 1'b0, 1'b1, 11);
        check("after timeout valid", key_valid, 1);
        check("after timeout code", key_code, 5);
        check("after timeout release", key_release, 0);
        check("after timeout no err", err_pulses - e0, 0);
        pop_one();

        // Wrong parity on 5A
        e0 = err_pulses;
        send_frame(8'h5A, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
        check("parity frame_err", err_pulses - e0, 1);
        check("parity no event", key_valid, 0);
        check("parity key_held", key_held, 6'b100000);
`else
        check("parity ignored err", err_pulses - e0, 0);
        check("parity ignored valid", key_valid, 1);
        check("parity ignored code", key_code, 4);
        check("parity ignored release", key_release, 0);
        check("parity ignored key_held", key_held, 6'b110000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
